// File: rtl/ab_stim_driver_if.sv
// rtl/ab_stim_driver_if.sv - load/stimulus/response bundle for ab_stim_driver
interface ab_stim_driver_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] a_word;
  logic [7:0] b_word;
  logic [2:0] len;
  logic       y_in;
  logic       z_in;
  logic       a;
  logic       b;
  logic       active;
  logic [7:0] y_word;
  logic [7:0] z_word;
  logic       done;

  modport master (
    output load_valid, a_word, b_word, len, y_in, z_in,
    input  load_ready, a, b, active, y_word, z_word, done
  );

  modport slave (
    input  load_valid, a_word, b_word, len, y_in, z_in,
    output load_ready, a, b, active, y_word, z_word, done
  );
endinterface

// File: rtl/ab_stim_driver.sv
// rtl/ab_stim_driver.sv - serial A/B stimulus driver with LAT-delayed Y/Z capture
// One cycle counter covers both drive (pair index) and drain; capture index is counter minus LAT.
module ab_stim_driver #(
  parameter int LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ab_stim_driver_if.slave    ab_bus
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_FIN} state_t;

  localparam logic [3:0] LAT4 = 4'(LAT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_a_word;
  logic [7:0] r_b_word;
  logic [7:0] r_y_word;
  logic [7:0] r_z_word;
  logic [2:0] r_len;
  logic [3:0] r_cyc;
  logic       r_a;
  logic       r_b;
  logic       w_load;
  logic       w_busy;
  logic       w_last_pair;
  logic       w_drain_end;
  logic       w_sample;
  logic [4:0] w_diff;
  logic [2:0] w_nxt_pair;

  assign w_busy      = (r_state == S_DRIVE) || (r_state == S_DRAIN);
  assign w_last_pair = (r_cyc == {1'b0, r_len});
  assign w_drain_end = (r_cyc == ({1'b0, r_len} + LAT4));
  // A borrow out of the subtraction means the first response is not due yet.
  assign w_diff      = {1'b0, r_cyc} - {1'b0, LAT4};
  assign w_sample    = w_busy && !w_diff[4];
  assign w_nxt_pair  = r_cyc[2:0] + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ab_bus.load_valid) begin
          w_next = S_DRIVE;
          w_load = 1'b1;
        end
      end
      S_DRIVE: begin
        if (w_last_pair) begin
          w_next = (LAT == 0) ? S_FIN : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_word <= 8'd0;
      r_b_word <= 8'd0;
      r_y_word <= 8'd0;
      r_z_word <= 8'd0;
      r_len    <= 3'd0;
      r_cyc    <= 4'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
    end else if (w_load) begin
      r_a_word <= ab_bus.a_word;
      r_b_word <= ab_bus.b_word;
      r_len    <= ab_bus.len;
      r_y_word <= 8'd0;
      r_z_word <= 8'd0;
      r_cyc    <= 4'd0;
      r_a      <= ab_bus.a_word[0];
      r_b      <= ab_bus.b_word[0];
    end else begin
      if (w_sample) begin
        r_y_word[w_diff[2:0]] <= ab_bus.y_in;
        r_z_word[w_diff[2:0]] <= ab_bus.z_in;
      end
      if (w_busy) begin
        r_cyc <= r_cyc + 4'd1;
      end
      // The next pair is launched on the edge that ends the current one.
      if ((r_state == S_DRIVE) && !w_last_pair) begin
        r_a <= r_a_word[w_nxt_pair];
        r_b <= r_b_word[w_nxt_pair];
      end else begin
        r_a <= 1'b0;
        r_b <= 1'b0;
      end
    end
  end

  assign ab_bus.load_ready = (r_state == S_IDLE);
  assign ab_bus.a          = r_a;
  assign ab_bus.b          = r_b;
  assign ab_bus.active     = w_busy;
  assign ab_bus.y_word     = r_y_word;
  assign ab_bus.z_word     = r_z_word;
  assign ab_bus.done       = (r_state == S_FIN);
endmodule

// File: doc/ab_stim_driver.md
AB_STIM_DRIVER -- requirements
Module: ab_stim_driver

Interface
REQ-001 Parameter LAT, default 1, meaning: cycles from presenting an A/B pair to sampling its response; legal range 0..3.
REQ-002 CLK  input  1  rising-edge clock; the block's only clock.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 LOAD_VALID  input  1  a load request is present.
REQ-005 LOAD_READY  output  1  the block can accept a load.
REQ-006 A_WORD  input  8  A stimulus bits, bit 0 sent first.
REQ-007 B_WORD  input  8  B stimulus bits, bit 0 sent first.
REQ-008 LEN  input  3  number of pairs minus one, so 1..8 pairs.
REQ-009 Y_IN  input  1  Y response sampled from the device under drive.
REQ-010 Z_IN  input  1  Z response sampled from the device under drive.
REQ-011 A  output  1  serial A stimulus, registered.
REQ-012 B  output  1  serial B stimulus, registered.
REQ-013 ACTIVE  output  1  high while driving or draining.
REQ-014 Y_WORD  output  8  captured Y responses, bit k for pair k.
REQ-015 Z_WORD  output  8  captured Z responses, bit k for pair k.
REQ-016 DONE  output  1  one-cycle completion pulse.

Function
REQ-017 The block SHALL implement the states IDLE, DRIVE, DRAIN and FIN.
REQ-018 In IDLE, LOAD_READY SHALL be 1; in all other states it SHALL be 0.
REQ-019 On a rising edge with LOAD_VALID=1 and LOAD_READY=1, the block SHALL capture A_WORD, B_WORD and LEN, clear Y_WORD and Z_WORD to 0, clear the pair counter, and enter DRIVE.
REQ-020 LOAD_VALID in any state other than IDLE SHALL be ignored, with no effect on the captured data.
REQ-021 In DRIVE, pair k SHALL appear on A/B for exactly one cycle, with k from 0 to LEN in order, starting the cycle after the load edge and with no gaps between pairs.
REQ-022 After pair LEN has been presented, the block SHALL enter DRAIN if LAT>0, or FIN if LAT=0.
REQ-023 DRAIN SHALL last exactly LAT cycles and then enter FIN.
REQ-024 Response bit k SHALL be Y_IN/Z_IN as sampled at the rising edge that ends cycle (t_k + LAT), where t_k is the cycle in which pair k is on A/B; it SHALL be written to Y_WORD[k]/Z_WORD[k].
REQ-025 Sampling SHALL occur only for k from 0 to LEN; bits above LEN SHALL remain 0.
REQ-026 In FIN, DONE SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-027 Y_WORD and Z_WORD SHALL hold their values from FIN until the next load is accepted.
REQ-028 A and B SHALL be 0 in every state other than DRIVE.
REQ-029 ACTIVE SHALL be 1 in DRIVE and DRAIN only.
REQ-030 With LEN=0, exactly one pair SHALL be driven.
REQ-031 With LEN=7, all 8 bits SHALL be driven and captured; the pair counter SHALL not wrap before the transition out of DRIVE.
REQ-032 A load request arriving in the same cycle as DONE SHALL not be accepted; it SHALL be accepted on the first IDLE cycle.

Reset
REQ-033 Asserting RST_N=0 SHALL immediately force state IDLE, A=0, B=0, ACTIVE=0, DONE=0, LOAD_READY=1, Y_WORD=0, Z_WORD=0 and clear all internal registers, regardless of the clock.
REQ-034 Reset asserted mid-DRIVE or mid-DRAIN SHALL abort the transfer without producing a DONE pulse.
REQ-035 After RST_N is released, the first accepted load SHALL behave identically to the first load after power-up.

Verification
REQ-036 LAT=1, LEN=3, A_WORD=8'h05, B_WORD=8'h0A, Y_IN tied to A delayed one cycle -> A sequence 1,0,1,0; B sequence 0,1,0,1; Y_WORD=8'h05; DONE pulses 5 cycles after the load edge.
REQ-037 LAT=0, LEN=0, A_WORD=8'hFF -> A high for exactly one cycle; Y_WORD bits 7..1 = 0; DONE on the second cycle after the load edge.
REQ-038 LEN=7, Z_IN=1 constantly -> 8 pairs driven, Z_WORD=8'hFF, ACTIVE high for 8+LAT cycles.
REQ-039 LOAD_VALID held high through an entire transfer, with A_WORD changed mid-transfer -> the new data is not used, and the second load is accepted on the cycle after DONE.
REQ-040 RST_N pulsed low at pair 2 of a LEN=5 transfer -> A=B=0 asynchronously, no DONE, and Y_WORD=0.
REQ-041 LAT=3, LEN=1, Y_IN pulsed high only in cycle t_1+3 -> Y_WORD=8'h02.
